stream_vadd_multi: RTL and testbench
====================================

Name: stream_vadd_multi

Overview:
- Parametrised successor of the two-input stream vector-add kernel.
- Consumes NUM_IN FIFO-style input streams and produces one output stream; every stream element carries an end-of-transfer (EOT) close-token bit.
- Computes an element-wise add or subtract on signed integers, with optional saturation.
- Uses an ap_ctrl_hs start/done/idle/ready handshake, detects premature or missing EOT, and sits between stream FIFOs inside a task graph.

Parameters:
- NUM_IN, 2, number of input streams (2..8).
- DATA_WIDTH, 32, payload width; each element is {eot, data[DATA_WIDTH-1:0]}.
- SATURATE, 0, 1 = clamp results to signed range; 0 = two's-complement wrap.

Ports:
- ap_clk  in  1  clock, all logic rising-edge.
- ap_rst  in  1  asynchronous active-high reset.
- ap_start  in  1  start request.
- ap_done  out  1  one-cycle pulse at completion.
- ap_idle  out  1  high when in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- n  in  64  element count, sampled on accepted start.
- mode  in  1  0 = sum of all inputs; 1 = in0 minus sum(in1..). Sampled on start.
- in_dout  in  NUM_IN*(DATA_WIDTH+1)  packed heads; channel k occupies bits [k*(DATA_WIDTH+1) +: DATA_WIDTH+1].
- in_empty_n  in  NUM_IN  head valid per channel.
- in_read  out  NUM_IN  consume head this cycle.
- out_din  out  DATA_WIDTH+1  output element {eot, data}.
- out_full_n  in  1  output FIFO has space.
- out_write  out  1  output element written this cycle.
- err_eot  out  1  sticky: EOT count mismatch in the last run.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, ap_idle=1, all other outputs 0, output register empty, count=0, err_eot=0.
- Reset mid-run: abort immediately. No EOT is emitted; partially consumed streams are the system's responsibility.
- FIFO semantics:
  - in_read[k] is asserted only when in_empty_n[k]=1; the head is consumed that cycle.
  - out_write = out_valid & out_full_n; the element is accepted that same cycle.
  - The output register may reload in the same cycle it drains.
- States:
  - IDLE: on ap_start=1, latch n and mode, clear err_eot and count, go to RUN. If n=0, go to FLUSH instead.
  - RUN: fire when every in_empty_n=1, no head has eot=1, and the output register is empty or draining this cycle.
    - On fire: assert all in_read, load out_din={0,result}, count++.
    - When count reaches n, go to FLUSH.
    - If any non-empty head has eot=1 before count reaches n, set err_eot and go to FLUSH without firing.
  - FLUSH: each cycle, read and discard every non-empty head with eot=0; set err_eot if any is discarded.
    - Once all heads are eot=1 (all in_empty_n=1), read all of them in one cycle and go to SEND_EOT.
  - SEND_EOT: wait until the output register is empty or draining, load {1, 0}, go to WAIT_EOT.
  - WAIT_EOT: when the EOT element is written, go to DONE.
  - DONE: pulse ap_done and ap_ready for one cycle, go to IDLE.
- ap_start while not IDLE is ignored. ap_start held high in DONE starts a new run on the following IDLE cycle.
- Latency: input fire at cycle t gives out_write at t+1 at earliest when out_full_n=1. Throughput is one element per cycle under full flow.
- Arithmetic:
  - Accumulate in DATA_WIDTH+clog2(NUM_IN)+1 signed bits.
  - SATURATE=0: truncate to DATA_WIDTH.
  - SATURATE=1: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Backpressure: with out_full_n=0, at most one result is held; inputs stall and no heads are consumed.
- Count is 64-bit; n=2^64-1 must not wrap before completion.

Test Plan:
- NUM_IN=2, mode=0, n=5, in0=0..4, in1=1..5, each followed by EOT:
  - out data 1,3,5,7,9, then {1,0}.
  - ap_done/ap_ready pulse once; err_eot=0.
- NUM_IN=4, mode=1, n=3, in0=10,20,30, in1..3 all 1:
  - out 7,17,27, then EOT.
- SATURATE=1, DATA_WIDTH=8, mode=0, in0=100, in1=100, n=1:
  - out data 127.
  - Same with SATURATE=0: out data 0xC8.
- n=4, but in1 sends EOT after 2 elements while in0 sends 4 elements + EOT:
  - out 2 results, then EOT.
  - in0's 2 extra data elements are discarded; err_eot=1.
- Random toggling of out_full_n and in_empty_n, n=100:
  - no element lost or duplicated, exactly one EOT, no in_read while empty, no out_write while full.
- ap_rst pulsed asynchronously mid-run (count=2):
  - all outputs 0 and ap_idle=1 immediately.
  - A new ap_start with n=0 produces EOT only, then ap_done.

Source files
------------

// File: rtl/stream_vadd_multi.sv
// Multi-input stream vector add/subtract kernel with an ap_ctrl_hs handshake.
// It closes every run with a single EOT element and flags EOT count mismatches.
module stream_vadd_multi #(
  parameter int NUM_IN     = 2,
  parameter int DATA_WIDTH = 32,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic                             ap_start,
  output logic                             ap_done,
  output logic                             ap_idle,
  output logic                             ap_ready,
  input  logic [63:0]                      n,
  input  logic                             mode,
  input  logic [NUM_IN*(DATA_WIDTH+1)-1:0] in_dout,
  input  logic [NUM_IN-1:0]                in_empty_n,
  output logic [NUM_IN-1:0]                in_read,
  output logic [DATA_WIDTH:0]              out_din,
  input  logic                             out_full_n,
  output logic                             out_write,
  output logic                             err_eot
);

  localparam int EW    = DATA_WIDTH + 1;
  localparam int ACC_W = DATA_WIDTH + $clog2(NUM_IN) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_FLUSH    = 3'd2,
    S_SEND_EOT = 3'd3,
    S_WAIT_EOT = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(ACC_W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fit_result(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] clamped;
    if (SATURATE && (acc > SAT_MAX)) begin
      clamped = SAT_MAX;
    end else if (SATURATE && (acc < SAT_MIN)) begin
      clamped = SAT_MIN;
    end else begin
      clamped = acc;
    end
    return clamped[DATA_WIDTH-1:0];
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [63:0]             r_n;
  logic [63:0]             r_count;
  logic                    r_mode;
  logic                    r_err;
  logic                    r_out_valid;
  logic [DATA_WIDTH:0]     r_out_data;

  logic [DATA_WIDTH-1:0]   w_data [NUM_IN];
  logic [NUM_IN-1:0]       w_eot;
  logic signed [ACC_W-1:0] w_acc;
  logic                    w_all_valid;
  logic                    w_head_eot;
  logic                    w_out_free;
  logic                    w_start_acc;
  logic                    w_fire;
  logic                    w_load_eot;
  logic                    w_err_set;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign w_data[g] = in_dout[g*EW +: DATA_WIDTH];
    assign w_eot[g]  = in_dout[g*EW + DATA_WIDTH];
  end

  assign w_all_valid = &in_empty_n;
  assign w_head_eot  = |(in_empty_n & w_eot);
  assign w_out_free  = ~r_out_valid | out_full_n;

  assign out_write = r_out_valid & out_full_n;
  assign out_din   = r_out_data;
  assign err_eot   = r_err;
  assign ap_idle   = (r_state == S_IDLE);
  assign ap_done   = (r_state == S_DONE);
  assign ap_ready  = (r_state == S_DONE);

  // Element-wise accumulation over all heads in the widened signed domain.
  always_comb begin
    w_acc = sext(w_data[0]);
    for (int k = 1; k < NUM_IN; k++) begin
      if (r_mode) begin
        w_acc = w_acc - sext(w_data[k]);
      end else begin
        w_acc = w_acc + sext(w_data[k]);
      end
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt = r_state;
    in_read     = {NUM_IN{1'b0}};
    w_start_acc = 1'b0;
    w_fire      = 1'b0;
    w_load_eot  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (n == 64'd0) ? S_FLUSH : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        // A close token before the count is met is a short stream.
        if (w_head_eot) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FLUSH;
        end else if (w_all_valid && w_out_free) begin
          w_fire      = 1'b1;
          in_read     = {NUM_IN{1'b1}};
          w_state_nxt = ((r_count + 64'd1) == r_n) ? S_FLUSH : S_RUN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        if (w_all_valid && (&w_eot)) begin
          in_read     = {NUM_IN{1'b1}};
          w_state_nxt = S_SEND_EOT;
        end else begin
          in_read     = in_empty_n & ~w_eot;
          w_err_set   = |(in_empty_n & ~w_eot);
          w_state_nxt = S_FLUSH;
        end
      end
      S_SEND_EOT: begin
        if (w_out_free) begin
          w_load_eot  = 1'b1;
          w_state_nxt = S_WAIT_EOT;
        end else begin
          w_state_nxt = S_SEND_EOT;
        end
      end
      S_WAIT_EOT: begin
        if (out_write) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT_EOT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, run parameters, element count and sticky EOT error.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_n     <= 64'd0;
      r_mode  <= 1'b0;
      r_count <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_n     <= n;
        r_mode  <= mode;
        r_count <= 64'd0;
        r_err   <= 1'b0;
      end else begin
        if (w_fire) begin
          r_count <= r_count + 64'd1;
        end
        if (w_err_set) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Single-entry output register; a load wins over a same-cycle drain.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= {1'b0, fit_result(w_acc)};
    end else if (w_load_eot) begin
      r_out_valid <= 1'b1;
      r_out_data  <= {1'b1, {DATA_WIDTH{1'b0}}};
    end else if (out_write) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_vadd_multi.sv
// Self-checking bench for stream_vadd_multi: four configurations share one set of
// stream models, and results are compared against an arithmetic reference.
module tb_stream_vadd_multi;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        ap_rst;
  logic [63:0] b_n;
  logic        b_mode;
  logic        b_start;
  logic        b_full;
  logic [3:0]  b_empty;
  logic [32:0] b_head [4];
  int          sel;

  logic [32:0] inq [4][$];
  logic [32:0] got_q [$];
  int          viol;
  int          ndone;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        d2_done, d2_idle, d2_ready, d2_write, d2_err;
  logic [1:0]  d2_read;
  logic [32:0] d2_out;
  logic        d4_done, d4_idle, d4_ready, d4_write, d4_err;
  logic [3:0]  d4_read;
  logic [32:0] d4_out;
  logic        s8_done, s8_idle, s8_ready, s8_write, s8_err;
  logic [1:0]  s8_read;
  logic [8:0]  s8_out;
  logic        w8_done, w8_idle, w8_ready, w8_write, w8_err;
  logic [1:0]  w8_read;
  logic [8:0]  w8_out;

  logic        a_done, a_idle, a_ready, a_write, a_err;
  logic [3:0]  a_read;
  logic [32:0] a_dout;

  stream_vadd_multi #(.NUM_IN(2), .DATA_WIDTH(32), .SATURATE(1'b0)) u_d2 (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(b_start && sel == 0),
    .ap_done(d2_done), .ap_idle(d2_idle), .ap_ready(d2_ready),
    .n(b_n), .mode(b_mode), .in_dout({b_head[1], b_head[0]}),
    .in_empty_n(sel == 0 ? b_empty[1:0] : 2'b00), .in_read(d2_read),
    .out_din(d2_out), .out_full_n(b_full), .out_write(d2_write), .err_eot(d2_err));

  stream_vadd_multi #(.NUM_IN(4), .DATA_WIDTH(32), .SATURATE(1'b0)) u_d4 (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(b_start && sel == 1),
    .ap_done(d4_done), .ap_idle(d4_idle), .ap_ready(d4_ready),
    .n(b_n), .mode(b_mode), .in_dout({b_head[3], b_head[2], b_head[1], b_head[0]}),
    .in_empty_n(sel == 1 ? b_empty : 4'b0000), .in_read(d4_read),
    .out_din(d4_out), .out_full_n(b_full), .out_write(d4_write), .err_eot(d4_err));

  stream_vadd_multi #(.NUM_IN(2), .DATA_WIDTH(8), .SATURATE(1'b1)) u_s8 (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(b_start && sel == 2),
    .ap_done(s8_done), .ap_idle(s8_idle), .ap_ready(s8_ready),
    .n(b_n), .mode(b_mode),
    .in_dout({b_head[1][32], b_head[1][7:0], b_head[0][32], b_head[0][7:0]}),
    .in_empty_n(sel == 2 ? b_empty[1:0] : 2'b00), .in_read(s8_read),
    .out_din(s8_out), .out_full_n(b_full), .out_write(s8_write), .err_eot(s8_err));

  stream_vadd_multi #(.NUM_IN(2), .DATA_WIDTH(8), .SATURATE(1'b0)) u_w8 (
    .ap_clk(clk), .ap_rst(ap_rst), .ap_start(b_start && sel == 3),
    .ap_done(w8_done), .ap_idle(w8_idle), .ap_ready(w8_ready),
    .n(b_n), .mode(b_mode),
    .in_dout({b_head[1][32], b_head[1][7:0], b_head[0][32], b_head[0][7:0]}),
    .in_empty_n(sel == 3 ? b_empty[1:0] : 2'b00), .in_read(w8_read),
    .out_din(w8_out), .out_full_n(b_full), .out_write(w8_write), .err_eot(w8_err));

  always_comb begin
    a_done = 1'b0; a_idle = 1'b0; a_ready = 1'b0; a_write = 1'b0; a_err = 1'b0;
    a_read = 4'd0; a_dout = 33'd0;
    case (sel)
      0: begin
        a_done = d2_done; a_idle = d2_idle; a_ready = d2_ready; a_write = d2_write;
        a_err = d2_err; a_read = {2'b00, d2_read}; a_dout = d2_out;
      end
      1: begin
        a_done = d4_done; a_idle = d4_idle; a_ready = d4_ready; a_write = d4_write;
        a_err = d4_err; a_read = d4_read; a_dout = d4_out;
      end
      2: begin
        a_done = s8_done; a_idle = s8_idle; a_ready = s8_ready; a_write = s8_write;
        a_err = s8_err; a_read = {2'b00, s8_read}; a_dout = {s8_out[8], 24'd0, s8_out[7:0]};
      end
      3: begin
        a_done = w8_done; a_idle = w8_idle; a_ready = w8_ready; a_write = w8_write;
        a_err = w8_err; a_read = {2'b00, w8_read}; a_dout = {w8_out[8], 24'd0, w8_out[7:0]};
      end
      default: begin
        a_done = 1'b0;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v, input int dw);
    longint t;
    t = longint'({32'd0, v}) << (64 - dw);
    return t >>> (64 - dw);
  endfunction

  // Reference: signed sum (or in0 minus the rest), then clamp or wrap to dw bits.
  function automatic logic [31:0] ref_elem(input int i, input int nch, input logic md,
                                           input int dw, input bit sat);
    longint      s;
    longint      lim;
    logic [32:0] e;
    e = inq[0][i];
    s = sx(e[31:0], dw);
    for (int k = 1; k < nch; k++) begin
      e = inq[k][i];
      if (md) s = s - sx(e[31:0], dw);
      else    s = s + sx(e[31:0], dw);
    end
    if (sat) begin
      lim = longint'(1) << (dw - 1);
      if (s > lim - 1) s = lim - 1;
      else if (s < -lim) s = -lim;
    end
    s = s & ((longint'(1) << dw) - 1);
    return s[31:0];
  endfunction

  task automatic push_d(input int k, input logic [31:0] v);
    inq[k].push_back({1'b0, v});
  endtask

  task automatic push_eot(input int k);
    inq[k].push_back({1'b1, 32'd0});
  endtask

  task automatic step(input int nch, input bit rnd, input bit st);
    logic [32:0] h;
    @(negedge clk);
    b_start = st;
    for (int k = 0; k < 4; k++) begin
      if (k < nch && inq[k].size() > 0) begin
        b_head[k]  = inq[k][0];
        b_empty[k] = !rnd || ($urandom_range(0, 3) != 0);
      end else begin
        b_head[k]  = 33'd0;
        b_empty[k] = 1'b0;
      end
    end
    b_full = !rnd || ($urandom_range(0, 2) != 0);
    #1;
    for (int k = 0; k < nch; k++) begin
      if (a_read[k]) begin
        if (!b_empty[k]) viol++;
        else h = inq[k].pop_front();
      end
    end
    if (a_write) begin
      if (!b_full) viol++;
      else got_q.push_back(a_dout);
    end
    if (a_done) ndone++;
    if (a_ready !== a_done) viol++;
  endtask

  task automatic run_test(input string tag, input int s, input int nch, input logic [63:0] nn,
                          input logic md, input bit rnd, input int exp_steps);
    logic [32:0] expq [$];
    logic [32:0] tmp;
    int          lens [4];
    int          m;
    bit          exp_err;
    int          dw;
    bit          sat;
    int          steps;
    int          budget;
    dw      = (s >= 2) ? 8 : 32;
    sat     = (s == 2);
    budget  = 3000;
    m       = (nn > 64'd1000000) ? 1000000 : int'(nn);
    exp_err = 1'b0;
    for (int k = 0; k < nch; k++) begin
      lens[k] = 0;
      while (lens[k] < inq[k].size()) begin
        tmp = inq[k][lens[k]];
        if (tmp[32]) break;
        lens[k]++;
      end
      if (lens[k] < m) m = lens[k];
      if (64'(lens[k]) != nn) exp_err = 1'b1;
    end
    for (int i = 0; i < m; i++) expq.push_back({1'b0, ref_elem(i, nch, md, dw, sat)});
    expq.push_back({1'b1, 32'd0});

    got_q.delete();
    sel = s; b_n = nn; b_mode = md; viol = 0; ndone = 0;
    for (steps = 0; steps < budget; steps++) begin
      step(nch, rnd, steps == 0);
      if (a_done) break;
    end
    step(nch, rnd, 1'b0);

    chk({tag, "_finished"}, 64'(steps < budget), 64'd1);
    chk({tag, "_done_pulses"}, 64'(ndone), 64'd1);
    chk({tag, "_protocol"}, 64'(viol), 64'd0);
    chk({tag, "_out_count"}, 64'(got_q.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < got_q.size(); i++)
      chk($sformatf("%s_out%0d", tag, i), 64'(got_q[i]), 64'(expq[i]));
    chk({tag, "_err_eot"}, 64'(a_err), 64'(exp_err));
    chk({tag, "_idle_after"}, 64'(a_idle), 64'd1);
    for (int k = 0; k < nch; k++)
      chk($sformatf("%s_drained%0d", tag, k), 64'(inq[k].size()), 64'd0);
    if (exp_steps > 0) chk({tag, "_latency"}, 64'(steps), 64'(exp_steps));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fires;
    ap_rst = 1'b1; b_start = 1'b0; b_full = 1'b1; b_empty = 4'd0; sel = 0;
    b_n = 64'd0; b_mode = 1'b0;
    for (int k = 0; k < 4; k++) b_head[k] = 33'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_idle", 64'(a_idle), 64'd1);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_write", 64'(a_write), 64'd0);
    chk("rst_read", 64'(a_read), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    @(negedge clk);
    ap_rst = 1'b0;

    for (int i = 0; i < 5; i++) begin push_d(0, 32'(i)); push_d(1, 32'(i + 1)); end
    push_eot(0); push_eot(1);
    run_test("t1_add2", 0, 2, 64'd5, 1'b0, 1'b0, 9);

    for (int i = 1; i <= 3; i++) begin
      push_d(0, 32'(10 * i));
      for (int k = 1; k < 4; k++) push_d(k, 32'd1);
    end
    for (int k = 0; k < 4; k++) push_eot(k);
    run_test("t2_sub4", 1, 4, 64'd3, 1'b1, 1'b0, 7);

    push_d(0, 32'd100); push_d(1, 32'd100); push_eot(0); push_eot(1);
    run_test("t3_sat8", 2, 2, 64'd1, 1'b0, 1'b0, 5);
    push_d(0, 32'd100); push_d(1, 32'd100); push_eot(0); push_eot(1);
    run_test("t3_wrap8", 3, 2, 64'd1, 1'b0, 1'b0, 5);

    for (int i = 0; i < 4; i++) push_d(0, 32'(5 + i));
    push_d(1, 32'd1); push_d(1, 32'd2);
    push_eot(0); push_eot(1);
    run_test("t4_early", 0, 2, 64'd4, 1'b0, 1'b0, 9);

    for (int i = 0; i < 100; i++) begin push_d(0, $urandom); push_d(1, $urandom); end
    push_eot(0); push_eot(1);
    run_test("t5_rand2", 0, 2, 64'd100, 1'($urandom_range(0, 1)), 1'b1, 0);

    for (int i = 0; i < 40; i++)
      for (int k = 0; k < 4; k++) push_d(k, $urandom);
    for (int k = 0; k < 4; k++) push_eot(k);
    run_test("t6_rand4", 1, 4, 64'd40, 1'b1, 1'b1, 0);

    for (int i = 0; i < 60; i++) begin push_d(0, $urandom); push_d(1, $urandom); end
    push_eot(0); push_eot(1);
    run_test("t7_randsat", 2, 2, 64'd60, 1'($urandom_range(0, 1)), 1'b1, 0);

    // Abort a run after two fires with an asynchronous reset, then run n=0.
    for (int i = 0; i < 10; i++) begin push_d(0, 32'(i)); push_d(1, 32'(i)); end
    push_eot(0); push_eot(1);
    got_q.delete(); viol = 0; ndone = 0; fires = 0;
    sel = 0; b_n = 64'd10; b_mode = 1'b0;
    step(2, 1'b0, 1'b1);
    for (int i = 0; i < 50 && fires < 2; i++) begin
      step(2, 1'b0, 1'b0);
      if (a_read[1:0] == 2'b11) fires++;
    end
    @(posedge clk);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("t8_fires", 64'(fires), 64'd2);
    chk("t8_rst_idle", 64'(a_idle), 64'd1);
    chk("t8_rst_done", 64'({a_done, a_ready}), 64'd0);
    chk("t8_rst_write", 64'(a_write), 64'd0);
    chk("t8_rst_read", 64'(a_read), 64'd0);
    chk("t8_rst_dout", 64'(a_dout), 64'd0);
    @(negedge clk);
    ap_rst = 1'b0;
    for (int k = 0; k < 4; k++) inq[k].delete();
    push_eot(0); push_eot(1);
    run_test("t8_n0", 0, 2, 64'd0, 1'b0, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
